// File: rtl/score_board_nway.sv
// -----------------------------------------------------------------------------
// score_board_nway
//   Multi-issue register scoreboard. One entry per architectural register
//   (register 0 is never tracked) records where the pending producer sits in
//   the post-issue pipeline (one-hot position vector, MSB = earliest stage),
//   which unit produces it (src tag), and whether it is a long-latency
//   producer that waits for an explicit completion strobe.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   stall             : global freeze, no entry changes
//   flush             : clear every entry; same-cycle writes are dropped
//   stage_stall_mask  : per-stage hold; an entry whose position overlaps it
//                       does not advance
//   wr_ena/addr/pos/
//   wr_src/wr_long    : ISSUE_W issue lanes, highest lane wins on conflicts
//   cpl_ena/cpl_addr  : long-latency completion, clears the long flag
//   rd_addr           : READ_W read addresses
//   rd_pos/src/busy/
//   rd_long           : registered-state view of each addressed entry
// -----------------------------------------------------------------------------
module score_board_nway #(
  parameter int NUM_REGS = 32,
  parameter int ISSUE_W  = 2,
  parameter int READ_W   = 4,
  parameter int DEPTH    = 3,
  parameter int SRC_W    = 2,
  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [DEPTH-1:0]         stage_stall_mask,
  input  logic [ISSUE_W-1:0]       wr_ena,
  input  logic [ISSUE_W*AW-1:0]    wr_addr,
  input  logic [ISSUE_W*DEPTH-1:0] wr_pos,
  input  logic [ISSUE_W*SRC_W-1:0] wr_src,
  input  logic [ISSUE_W-1:0]       wr_long,
  input  logic                     cpl_ena,
  input  logic [AW-1:0]            cpl_addr,
  input  logic [READ_W*AW-1:0]     rd_addr,
  output logic [READ_W*DEPTH-1:0]  rd_pos,
  output logic [READ_W*SRC_W-1:0]  rd_src,
  output logic [READ_W-1:0]        rd_busy,
  output logic [READ_W-1:0]        rd_long
);

  // Flat views of every entry's registered state, indexed by register number.
  logic [DEPTH-1:0] ent_pos  [NUM_REGS];
  logic [SRC_W-1:0] ent_src  [NUM_REGS];
  logic             ent_long [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Entry update
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
    logic [DEPTH-1:0] pos_q, pos_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic             long_q, long_d;
    logic             wr_hit;

    always_comb begin
      pos_d  = pos_q;
      src_d  = src_q;
      long_d = long_q;
      wr_hit = 1'b0;

      // Ascending lane scan: a later lane overwrites an earlier one, so the
      // highest-numbered lane wins an address conflict. Entry 0 never loads.
      for (int k = 0; k < ISSUE_W; k++) begin
        if ((gi != 0) && wr_ena[k] && (wr_addr[k*AW +: AW] == AW'(gi))) begin
          wr_hit = 1'b1;
          pos_d  = wr_pos[k*DEPTH +: DEPTH];
          src_d  = wr_src[k*SRC_W +: SRC_W];
          long_d = wr_long[k];
        end
      end

      if (!wr_hit) begin
        if (long_q) begin
          // Long producers sit still until completed; the completion cycle
          // itself does not shift, so advancing resumes on the next cycle.
          if (cpl_ena && (cpl_addr == AW'(gi))) begin
            long_d = 1'b0;
          end
        end else if ((pos_q & stage_stall_mask) == '0) begin
          if ((pos_q >> 1) == '0) begin
            // Retiring out of the last stage clears the whole entry.
            pos_d = '0;
            src_d = '0;
          end else begin
            pos_d = pos_q >> 1;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        pos_q  <= '0;
        src_q  <= '0;
        long_q <= 1'b0;
      end else if (!stall) begin
        pos_q  <= pos_d;
        src_q  <= src_d;
        long_q <= long_d;
      end
    end

    assign ent_pos[gi]  = pos_q;
    assign ent_src[gi]  = src_q;
    assign ent_long[gi] = long_q;
  end

  // ---------------------------------------------------------------------------
  // Read ports: registered state only, address 0 (or out of range) reads zero
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < READ_W; gi++) begin : g_read
    logic [AW-1:0] ra;
    logic          ra_ok;

    assign ra    = rd_addr[gi*AW +: AW];
    assign ra_ok = (ra != '0) && ({1'b0, ra} < (AW+1)'(NUM_REGS));

    assign rd_pos[gi*DEPTH +: DEPTH] = ra_ok ? ent_pos[ra] : '0;
    assign rd_src[gi*SRC_W +: SRC_W] = ra_ok ? ent_src[ra] : '0;
    assign rd_long[gi]               = ra_ok && ent_long[ra];
    assign rd_busy[gi]               = ra_ok && ((ent_pos[ra] != '0) || ent_long[ra]);
  end

endmodule

// File: tb/tb_score_board_nway.sv
module tb_score_board_nway;

  localparam int NR = 32;
  localparam int IW = 2;
  localparam int RW = 4;
  localparam int DP = 3;
  localparam int SW = 2;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst, stall, flush;
  logic [DP-1:0]    mask;
  logic [IW-1:0]    wr_ena;
  logic [IW*AW-1:0] wr_addr;
  logic [IW*DP-1:0] wr_pos;
  logic [IW*SW-1:0] wr_src;
  logic [IW-1:0]    wr_long;
  logic             cpl_ena;
  logic [AW-1:0]    cpl_addr;
  logic [RW*AW-1:0] rd_addr;
  logic [RW*DP-1:0] rd_pos;
  logic [RW*SW-1:0] rd_src;
  logic [RW-1:0]    rd_busy;
  logic [RW-1:0]    rd_long;

  score_board_nway dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .stage_stall_mask(mask),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_pos(wr_pos),
    .wr_src(wr_src), .wr_long(wr_long),
    .cpl_ena(cpl_ena), .cpl_addr(cpl_addr),
    .rd_addr(rd_addr), .rd_pos(rd_pos), .rd_src(rd_src),
    .rd_busy(rd_busy), .rd_long(rd_long)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit track    = 1'b0;

  // Reference state: plain integers per register.
  int m_pos  [NR];
  int m_src  [NR];
  int m_long [NR];

  typedef struct {
    logic [RW*DP-1:0] pos;
    logic [RW*SW-1:0] src;
    logic [RW-1:0]    busy;
    logic [RW-1:0]    lng;
  } exp_t;
  exp_t exp_q[$];

  // Apply one clock edge's worth of rules to the reference state.
  task automatic model_step();
    if (rst || flush) begin
      for (int r = 0; r < NR; r++) begin
        m_pos[r] = 0; m_src[r] = 0; m_long[r] = 0;
      end
    end else if (!stall) begin
      for (int r = 1; r < NR; r++) begin
        bit written = 1'b0;
        for (int k = 0; k < IW; k++) begin
          if (wr_ena[k] && int'(wr_addr[k*AW +: AW]) == r) begin
            m_pos[r]  = int'(wr_pos[k*DP +: DP]);
            m_src[r]  = int'(wr_src[k*SW +: SW]);
            m_long[r] = int'(wr_long[k]);
            written   = 1'b1;
          end
        end
        if (!written) begin
          if (m_long[r] != 0) begin
            if (cpl_ena && int'(cpl_addr) == r) m_long[r] = 0;
          end else if ((m_pos[r] & int'(mask)) == 0) begin
            m_pos[r] = m_pos[r] / 2;
            if (m_pos[r] == 0) m_src[r] = 0;
          end
        end
      end
    end
  endtask

  // Record what the read ports must show this cycle, then advance the model.
  task automatic issue();
    exp_t e;
    if (track) begin
      for (int p = 0; p < RW; p++) begin
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        e.pos[p*DP +: DP] = DP'(m_pos[a]);
        e.src[p*SW +: SW] = SW'(m_src[a]);
        e.busy[p]         = (m_pos[a] != 0) || (m_long[a] != 0);
        e.lng[p]          = (m_long[a] != 0);
      end
      exp_q.push_back(e);
    end
    model_step();
  endtask

  task automatic start_cycle();
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; flush = 1'b0; mask = '0;
    wr_ena = '0; wr_addr = '0; wr_pos = '0; wr_src = '0; wr_long = '0;
    cpl_ena = 1'b0; cpl_addr = '0;
  endtask

  task automatic set_wr(input int k, input int a, input int p, input int s, input int l);
    wr_ena[k]            = 1'b1;
    wr_addr[k*AW +: AW]  = AW'(a);
    wr_pos[k*DP +: DP]   = DP'(p);
    wr_src[k*SW +: SW]   = SW'(s);
    wr_long[k]           = (l != 0);
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // Directed check of one read port against constants from the scenarios.
  task automatic chk(input string name, input int p, input int epos,
                     input int esrc, input int ebusy, input int elong);
    int apos, asrc, abusy, along;
    apos  = int'(rd_pos[p*DP +: DP]);
    asrc  = int'(rd_src[p*SW +: SW]);
    abusy = int'(rd_busy[p]);
    along = int'(rd_long[p]);
    checks++;
    if (apos != epos || asrc != esrc || abusy != ebusy || along != elong) begin
      failures++;
      $display("FAIL %s port%0d: got pos=%03b src=%0d busy=%0d long=%0d, expected pos=%03b src=%0d busy=%0d long=%0d",
               name, p, apos, asrc, abusy, along, epos, esrc, ebusy, elong);
    end else begin
      $display("chk %s port%0d pos=%03b src=%0d busy=%0d long=%0d ok",
               name, p, apos, asrc, abusy, along);
    end
  endtask

  // Monitor: read ports are presented every cycle; compare against the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int p = 0; p < RW; p++) begin
          checks++;
          if (rd_pos[p*DP +: DP] !== e.pos[p*DP +: DP] ||
              rd_src[p*SW +: SW] !== e.src[p*SW +: SW] ||
              rd_busy[p] !== e.busy[p] || rd_long[p] !== e.lng[p]) begin
            failures++;
            $display("FAIL scoreboard t=%0t port%0d addr=%0d: got pos=%03b src=%0d busy=%b long=%b, expected pos=%03b src=%0d busy=%b long=%b",
                     $time, p, rd_addr[p*AW +: AW],
                     rd_pos[p*DP +: DP], rd_src[p*SW +: SW], rd_busy[p], rd_long[p],
                     e.pos[p*DP +: DP], e.src[p*SW +: SW], e.busy[p], e.lng[p]);
          end
        end
      end
    end
  end

  initial begin
    int sp [4] = '{4, 2, 1, 0};
    int ss [4] = '{1, 1, 1, 0};
    rst = 1'b1; stall = 1'b0; flush = 1'b0; mask = '0;
    wr_ena = '0; wr_addr = '0; wr_pos = '0; wr_src = '0; wr_long = '0;
    cpl_ena = 1'b0; cpl_addr = '0; rd_addr = '0;
    for (int r = 0; r < NR; r++) begin
      m_pos[r] = 0; m_src[r] = 0; m_long[r] = 0;
    end

    // Reset
    repeat (2) begin
      start_cycle(); rst = 1'b1; issue();
    end
    track = 1'b1;
    start_cycle(); set_rd(0, 5); set_rd(1, 1); set_rd(2, 17); set_rd(3, 31); issue(); #2;
    chk("reset_r5", 0, 0, 0, 0, 0);
    chk("reset_r31", 3, 0, 0, 0, 0);

    // Shift: r5 walks 100 -> 010 -> 001 -> 000
    start_cycle(); set_wr(0, 5, 4, 1, 0); set_rd(0, 5); issue();
    for (int i = 0; i < 4; i++) begin
      start_cycle(); issue(); #2;
      chk($sformatf("shift%0d", i), 0, sp[i], ss[i], (sp[i] != 0) ? 1 : 0, 0);
    end

    // Stage hold on r7
    start_cycle(); set_wr(0, 7, 2, 2, 0); set_rd(0, 7); issue();
    for (int i = 0; i < 3; i++) begin
      start_cycle(); mask = 3'b010; issue(); #2;
      chk($sformatf("hold%0d", i), 0, 2, 2, 1, 0);
    end
    start_cycle(); issue(); #2; chk("hold_last", 0, 2, 2, 1, 0);
    start_cycle(); issue(); #2; chk("hold_release", 0, 1, 2, 1, 0);

    // Lane conflict on r3, write to r0 ignored
    start_cycle(); set_wr(0, 3, 4, 2, 0); set_wr(1, 3, 4, 3, 0); set_rd(0, 3); issue();
    start_cycle(); set_wr(0, 0, 4, 1, 1); set_rd(1, 0); issue(); #2;
    chk("lane_win", 0, 4, 3, 1, 0);
    start_cycle(); issue(); #2;
    chk("wr_r0", 1, 0, 0, 0, 0);

    // Long-latency r9
    start_cycle(); set_wr(1, 9, 1, 1, 1); set_rd(0, 9); issue();
    for (int i = 0; i < 10; i++) begin
      start_cycle(); mask = 3'($urandom); issue(); #2;
      chk($sformatf("long_hold%0d", i), 0, 1, 1, 1, 1);
    end
    start_cycle(); cpl_ena = 1'b1; cpl_addr = 5'd9; issue(); #2;
    chk("long_cpl_cycle", 0, 1, 1, 1, 1);
    start_cycle(); issue(); #2; chk("long_after_cpl", 0, 1, 1, 1, 0);
    start_cycle(); issue(); #2; chk("long_cleared", 0, 0, 0, 0, 0);

    // Global freeze
    start_cycle(); set_wr(0, 6, 2, 1, 0); set_rd(0, 6); set_rd(1, 4); issue();
    for (int i = 0; i < 2; i++) begin
      start_cycle(); stall = 1'b1; set_wr(0, 4, 2, 2, 0); set_wr(1, 6, 4, 3, 0); issue(); #2;
      chk($sformatf("freeze_r6_%0d", i), 0, 2, 1, 1, 0);
      chk($sformatf("freeze_r4_%0d", i), 1, 0, 0, 0, 0);
    end
    start_cycle(); issue(); #2; chk("freeze_end_r6", 0, 2, 1, 1, 0);
    chk("freeze_end_r4", 1, 0, 0, 0, 0);
    start_cycle(); issue(); #2; chk("unfreeze_r6", 0, 1, 1, 1, 0);

    // Flush with a same-cycle write to r8
    start_cycle(); set_wr(0, 10, 1, 2, 1); set_wr(1, 11, 4, 1, 0);
    set_rd(0, 10); set_rd(1, 11); set_rd(2, 8); issue();
    start_cycle(); flush = 1'b1; set_wr(0, 8, 4, 3, 1); issue(); #2;
    chk("pre_flush_r10", 0, 1, 2, 1, 1);
    start_cycle(); issue(); #2;
    chk("flush_r10", 0, 0, 0, 0, 0);
    chk("flush_r11", 1, 0, 0, 0, 0);
    chk("flush_r8", 2, 0, 0, 0, 0);

    // Reset mid-operation with a same-cycle write to r8
    start_cycle(); set_wr(0, 10, 1, 2, 1); set_wr(1, 11, 4, 1, 0); issue();
    start_cycle(); rst = 1'b1; set_wr(0, 8, 4, 3, 1); cpl_ena = 1'b1; cpl_addr = 5'd10; issue(); #2;
    chk("pre_rst_r11", 1, 4, 1, 1, 0);
    start_cycle(); issue(); #2;
    chk("rst_r10", 0, 0, 0, 0, 0);
    chk("rst_r11", 1, 0, 0, 0, 0);
    chk("rst_r8", 2, 0, 0, 0, 0);

    // Randomized traffic, small address range to force collisions
    for (int n = 0; n < 4000; n++) begin
      start_cycle();
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 9) == 0);
      mask  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      for (int k = 0; k < IW; k++) begin
        wr_ena[k]           = ($urandom_range(0, 1) == 1);
        wr_addr[k*AW +: AW] = 5'($urandom_range(0, 12));
        wr_pos[k*DP +: DP]  = 3'(1 << $urandom_range(0, 2));
        wr_src[k*SW +: SW]  = 2'($urandom);
        wr_long[k]          = ($urandom_range(0, 4) == 0);
      end
      cpl_ena  = ($urandom_range(0, 2) == 0);
      cpl_addr = 5'($urandom_range(0, 12));
      for (int p = 0; p < RW; p++) begin
        set_rd(p, ($urandom_range(0, 19) == 0) ? 31 : $urandom_range(0, 13));
      end
      issue();
    end

    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
